// File: rtl/alu_exec_unit.sv
// Execute-stage ALU for KGP-RISC: single-cycle arithmetic/logic, 1 bit/cycle shifts,
// valid/ready handshakes on both sides and an architectural carry register for bcy/bncy.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         ALUOps,
    input  logic [WIDTH-1:0]   OpA,
    input  logic [WIDTH-1:0]   OpB,
    input  logic [SHAMT_W-1:0] Shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   Result,
    output logic               Carry,
    output logic               Zero,
    output logic               Sign,
    output logic               CarryFlag
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [1:0] SH_LEFT = 2'd0;
    localparam logic [1:0] SH_LRS  = 2'd1;
    localparam logic [1:0] SH_ARS  = 2'd2;

    state_t state, nextState;

    logic [WIDTH-1:0]   workReg;
    logic [SHAMT_W-1:0] shiftCnt;
    logic [1:0]         shiftKind;
    logic               flagUpd;

    logic               isShift;
    logic               isVar;
    logic [1:0]         decKind;
    logic               decFlagWr;
    logic [SHAMT_W-1:0] shAmt;
    logic               startShift;
    logic [WIDTH-1:0]   aluRes;
    logic               aluCarry;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     dif;
    logic [WIDTH-1:0]   stepRes;
    logic               stepCarry;

    // Operation decode and single-cycle datapath, evaluated on the presented operands
    always_comb begin
        isShift   = 1'b0;
        isVar     = 1'b0;
        decKind   = SH_LEFT;
        decFlagWr = 1'b1;
        aluRes    = '0;
        aluCarry  = 1'b0;
        sum       = {1'b0, OpA} + {1'b0, OpB};
        dif       = {1'b0, OpA} + {1'b0, ~OpB} + (WIDTH+1)'(1);
        case (ALUOps)
            4'b1010: begin aluRes = sum[WIDTH-1:0]; aluCarry = sum[WIDTH]; end
            4'b1011: begin aluRes = dif[WIDTH-1:0]; aluCarry = dif[WIDTH]; end
            4'b1111: begin aluRes = ~OpB + WIDTH'(1); aluCarry = (OpB == '0); end
            4'b1000: aluRes = OpA & OpB;
            4'b1001: aluRes = OpA ^ OpB;
            4'b1110: begin aluRes = OpA; decFlagWr = 1'b0; end
            4'b0000: begin isShift = 1'b1; aluRes = OpA; end
            4'b0100: begin isShift = 1'b1; isVar = 1'b1; aluRes = OpA; end
            4'b0001: begin isShift = 1'b1; decKind = SH_LRS; aluRes = OpA; end
            4'b0101: begin isShift = 1'b1; isVar = 1'b1; decKind = SH_LRS; aluRes = OpA; end
            4'b0010: begin isShift = 1'b1; decKind = SH_ARS; aluRes = OpA; end
            4'b0011: begin isShift = 1'b1; isVar = 1'b1; decKind = SH_ARS; aluRes = OpA; end
            default: decFlagWr = 1'b0;
        endcase
        shAmt      = isVar ? OpB[SHAMT_W-1:0] : Shamt;
        startShift = isShift && (shAmt != '0);
    end

    always_comb begin
        stepRes   = workReg << 1;
        stepCarry = workReg[WIDTH-1];
        case (shiftKind)
            SH_LRS: begin stepRes = workReg >> 1; stepCarry = workReg[0]; end
            SH_ARS: begin stepRes = {workReg[WIDTH-1], workReg[WIDTH-1:1]}; stepCarry = workReg[0]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nextState = startShift ? SHIFT : DONE;
            end
            SHIFT: if (shiftCnt == SHAMT_W'(1)) nextState = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Result and flags only change when an operation finishes, so they hold through SHIFT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            workReg   <= '0;
            shiftCnt  <= '0;
            shiftKind <= SH_LEFT;
            flagUpd   <= 1'b0;
            Result    <= '0;
            Carry     <= 1'b0;
            Zero      <= 1'b0;
            Sign      <= 1'b0;
            CarryFlag <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    flagUpd <= decFlagWr;
                    if (startShift) begin
                        workReg   <= OpA;
                        shiftCnt  <= shAmt;
                        shiftKind <= decKind;
                    end else begin
                        Result <= aluRes;
                        Carry  <= aluCarry;
                        Zero   <= (aluRes == '0);
                        Sign   <= aluRes[WIDTH-1];
                    end
                end
                SHIFT: begin
                    workReg  <= stepRes;
                    shiftCnt <= shiftCnt - SHAMT_W'(1);
                    if (shiftCnt == SHAMT_W'(1)) begin
                        Result <= stepRes;
                        Carry  <= stepCarry;
                        Zero   <= (stepRes == '0);
                        Sign   <= stepRes[WIDTH-1];
                    end
                end
                DONE: if (out_ready && flagUpd) CarryFlag <= Carry;
                default: ;
            endcase
        end
    end

endmodule
